// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, word width and error causes.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISALIGN,
        ERR_RANGE,
        ERR_CONFLICT
    } err_cause_e;

    // First matching cause wins: alignment, then range, then read/write conflict.
    function automatic err_cause_e check_req(
        input logic [WORD_W-1:0] addr,
        input logic              rd,
        input logic              wr,
        input logic [WORD_W-1:0] limit
    );
        if (addr[1:0] != 2'b00) return ERR_MISALIGN;
        if (addr >= limit)      return ERR_RANGE;
        if (rd && wr)           return ERR_CONFLICT;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store bus between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic                         memread;
    logic                         memwrite;
    logic [dmem_pkg::WORD_W-1:0]  dir;
    logic [dmem_pkg::WORD_W-1:0]  dati;
    logic [dmem_pkg::WORD_W-1:0]  dato;
    logic                         busy;
    logic                         done;
    logic                         err;

    modport master (
        output memread, memwrite, dir, dati,
        input  dato, busy, done, err
    );

    modport slave (
        input  memread, memwrite, dir, dati,
        output dato, busy, done, err
    );

endinterface

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with write enable and enabled registered read; not reset.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic                           re_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [dmem_pkg::WORD_W-1:0]    wdata_i,
    output logic [dmem_pkg::WORD_W-1:0]    rdata_o
);

    logic [dmem_pkg::WORD_W-1:0] mem_q [DEPTH_WORDS];

    // Read port only updates on an enabled read so the last load result is held.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: captures a load/store, inserts wait states,
// performs the access on the edge entering RESP and pulses done/err for one cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int unsigned       AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned       CNT_W   = 4;
    localparam logic [WORD_W-1:0] LIMIT   = WORD_W'(4 * DEPTH_WORDS);
    localparam bit                NO_WAIT = (WAIT_CYCLES == 0);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] dati_q;
    logic              store_q;
    err_cause_e        cause_q;
    logic              done_q;
    logic              err_q;
    logic              zero_q;

    logic              req_c;
    logic              store_live_c;
    err_cause_e        cause_live_c;
    logic              finish_c;
    logic [AW-1:0]     acc_idx_c;
    logic [WORD_W-1:0] acc_dati_c;
    logic              acc_store_c;
    logic              acc_ok_c;
    logic              we_c;
    logic              re_c;
    logic [WORD_W-1:0] rdata;

    assign req_c        = bus.memread | bus.memwrite;
    assign store_live_c = bus.memwrite & ~bus.memread;
    assign cause_live_c = check_req(bus.dir, bus.memread, bus.memwrite, LIMIT);

    // With no wait states the access uses the live request; otherwise the captured one.
    always_comb begin
        acc_idx_c   = idx_q;
        acc_dati_c  = dati_q;
        acc_store_c = store_q;
        acc_ok_c    = (cause_q == ERR_NONE);
        finish_c    = 1'b0;
        if (state_q == IDLE) begin
            acc_idx_c   = bus.dir[AW+1:2];
            acc_dati_c  = bus.dati;
            acc_store_c = store_live_c;
            acc_ok_c    = (cause_live_c == ERR_NONE);
            finish_c    = req_c && NO_WAIT;
        end else if (state_q == WAIT) begin
            finish_c    = (cnt_q == '0);
        end
    end

    assign we_c = finish_c & acc_store_c  & acc_ok_c & rst_n;
    assign re_c = finish_c & ~acc_store_c & acc_ok_c & rst_n;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (we_c),
        .re_i    (re_c),
        .addr_i  (acc_idx_c),
        .wdata_i (acc_dati_c),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dati_q  <= '0;
            store_q <= 1'b0;
            cause_q <= ERR_NONE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        idx_q   <= bus.dir[AW+1:2];
                        dati_q  <= bus.dati;
                        store_q <= store_live_c;
                        cause_q <= cause_live_c;
                        if (NO_WAIT) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) state_q <= RESP;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            // A completing load decides whether dato shows RAM data or zero.
            if (finish_c) begin
                done_q <= 1'b1;
                err_q  <= ~acc_ok_c;
                if (!acc_store_c) zero_q <= ~acc_ok_c;
            end
        end
    end

    assign bus.busy = ((state_q == IDLE) && req_c) || (state_q == WAIT);
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.dato = zero_q ? '0 : rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed ops push expectations, a monitor checks each done.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WA    = 2;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] dato;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus_a ();
    dmem_responder_if bus_b ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) u_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a)
    );
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    time  t_a[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_push = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expectation for that DUT.
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.done === 1'b1) begin
            n_done++;
            t_a.push_back($time);
            if (q_a.size() == 0) check("A unexpected done", 32'd1, 32'd0);
            else begin
                e = q_a.pop_front();
                check("A err", 32'(bus_a.err), 32'(e.err));
                if (e.chk) check("A dato", bus_a.dato, e.dato);
            end
        end
        if (bus_b.done === 1'b1) begin
            n_done++;
            if (q_b.size() == 0) check("B unexpected done", 32'd1, 32'd0);
            else begin
                e = q_b.pop_front();
                check("B err", 32'(bus_b.err), 32'(e.err));
                if (e.chk) check("B dato", bus_b.dato, e.dato);
            end
        end
    end

    task automatic drive(input int which, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        if (which == 0) begin
            bus_a.memread = rd; bus_a.memwrite = wr; bus_a.dir = addr; bus_a.dati = data;
        end else begin
            bus_b.memread = rd; bus_b.memwrite = wr; bus_b.dir = addr; bus_b.dati = data;
        end
    endtask

    function automatic logic busy_of(input int which);
        return (which == 0) ? bus_a.busy : bus_b.busy;
    endfunction

    function automatic logic done_of(input int which);
        return (which == 0) ? bus_a.done : bus_b.done;
    endfunction

    // Called just after a rising edge; holds the request until the edge closing its done cycle.
    task automatic do_op(input int which, input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_err, input logic chk, input logic [31:0] exp_dato);
        exp_t e;
        int   k       = 0;
        int   busy_n  = 0;
        int   done_at = -1;
        int   lat     = (which == 0) ? int'(WA) + 1 : 1;
        e.err = exp_err; e.chk = chk; e.dato = exp_dato;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
        n_push++;
        drive(which, rd, wr, addr, data);
        while (done_at < 0 && k < 40) begin
            @(negedge clk);
            if (busy_of(which) === 1'b1) busy_n++;
            if (done_of(which) === 1'b1) done_at = k;
            k++;
        end
        check({tag, " latency"}, 32'(done_at), 32'(lat));
        check({tag, " busy cycles"}, 32'(busy_n), 32'(lat));
        @(posedge clk); #1;
        drive(which, 1'b0, 1'b0, addr, data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(bus_a.busy), 32'd0);
        check("reset done", 32'(bus_a.done), 32'd0);
        check("reset err",  32'(bus_a.err),  32'd0);
        check("reset dato", bus_a.dato, 32'h0);
        check("reset state", 32'(u_a.state_q), 32'(IDLE));
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, "st 10",    1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        do_op(0, "ld 10",    1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
        do_op(0, "st 12",    1'b0, 1'b1, 32'h12,  32'h0BADF00D, 1'b1, 1'b0, 32'h0);
        check("dato held after store", bus_a.dato, 32'hDEADBEEF);
        do_op(0, "ld 10 re", 1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
        do_op(0, "ld range", 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b1, 1'b1, 32'h0);
        do_op(0, "st 20",    1'b0, 1'b1, 32'h20,  32'h11112222, 1'b0, 1'b0, 32'h0);
        do_op(0, "conflict", 1'b1, 1'b1, 32'h20,  32'h55,       1'b1, 1'b0, 32'h0);
        do_op(0, "ld 20",    1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 1'b1, 32'h11112222);
        do_op(0, "st 08",    1'b0, 1'b1, 32'h08,  32'hAAAA5555, 1'b0, 1'b0, 32'h0);
        do_op(0, "st 00",    1'b0, 1'b1, 32'h00,  32'h01010101, 1'b0, 1'b0, 32'h0);
        do_op(0, "st 04",    1'b0, 1'b1, 32'h04,  32'h02020202, 1'b0, 1'b0, 32'h0);

        // Abort a store of 0x1234 to 0x08 while it sits in WAIT.
        drive(0, 1'b0, 1'b1, 32'h08, 32'h1234);
        @(negedge clk);
        check("abort busy before reset", 32'(bus_a.busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("abort busy", 32'(bus_a.busy), 32'd0);
        check("abort done", 32'(bus_a.done), 32'd0);
        check("abort err",  32'(bus_a.err),  32'd0);
        check("abort dato", bus_a.dato, 32'h0);
        check("abort state", 32'(u_a.state_q), 32'(IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(0, "b2b 00", 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 1'b1, 32'h01010101);
        do_op(0, "b2b 04", 1'b1, 1'b0, 32'h04, 32'h0, 1'b0, 1'b1, 32'h02020202);
        do_op(0, "b2b 08", 1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b1, 32'hAAAA5555);
        if (t_a.size() >= 3) begin
            check("b2b spacing 1", 32'(t_a[t_a.size()-2] - t_a[t_a.size()-3]), 32'(10 * (WA + 2)));
            check("b2b spacing 2", 32'(t_a[t_a.size()-1] - t_a[t_a.size()-2]), 32'(10 * (WA + 2)));
        end else begin
            check("b2b pulse count", 32'(t_a.size()), 32'd3);
        end

        do_op(1, "w0 st 00", 1'b0, 1'b1, 32'h00, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        do_op(1, "w0 ld 00", 1'b1, 1'b0, 32'h00, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
        do_op(1, "w0 ld 02", 1'b1, 1'b0, 32'h02, 32'h0,        1'b1, 1'b1, 32'h0);

        repeat (6) @(posedge clk);
        #1;
        check("done count", 32'(n_done), 32'(n_push));
        check("A queue empty", 32'(q_a.size()), 32'd0);
        check("B queue empty", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
